// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: drives the register-file write port, serialises
// swap (two-write) instructions, and keeps the sticky overflow and halt state.
module wb_write_sequencer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned PROTECT_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  input  logic              RegWrite,
  input  logic              WriteOP2,
  input  logic              Halt,
  input  logic              Overflow,
  input  logic [ADDR_W-1:0] DestOP1,
  input  logic [ADDR_W-1:0] DestOP2,
  input  logic [DATA_W-1:0] ResultOP1,
  input  logic [DATA_W-1:0] ResultOP2,
  output logic              Stall,
  output logic              RFWriteEn,
  output logic [ADDR_W-1:0] RFWriteAddr,
  output logic [DATA_W-1:0] RFWriteData,
  output logic              OverflowFlag,
  output logic [7:0]        OverflowCount,
  output logic              Halted
);

  typedef enum logic [1:0] {IDLE, WR1, WR2, HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              accept;

  assign Stall  = (state == WR1) || (state == HALTED);
  assign accept = InValid && !Stall;

  // Writes to r0 are suppressed when the register is hard-wired.
  function automatic logic write_allowed(input logic [ADDR_W-1:0] addr);
    return !((PROTECT_R0 != 0) && (addr == '0));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pend_addr     <= '0;
      pend_data     <= '0;
      RFWriteEn     <= 1'b0;
      RFWriteAddr   <= '0;
      RFWriteData   <= '0;
      OverflowFlag  <= 1'b0;
      OverflowCount <= 8'd0;
      Halted        <= 1'b0;
    end else begin
      RFWriteEn <= 1'b0;
      case (state)
        IDLE, WR2: begin
          state <= IDLE;
          if (accept) begin
            if (Halt) begin
              state  <= HALTED;
              Halted <= 1'b1;
            end else if (RegWrite && Overflow) begin
              OverflowFlag <= 1'b1;
              if (OverflowCount != 8'hFF) begin
                OverflowCount <= OverflowCount + 8'd1;
              end
            end else if (RegWrite) begin
              RFWriteEn   <= write_allowed(DestOP1);
              RFWriteAddr <= DestOP1;
              RFWriteData <= ResultOP1;
              if (WriteOP2) begin
                pend_addr <= DestOP2;
                pend_data <= ResultOP2;
                state     <= WR1;
              end
            end
          end
        end
        // Second half of a swap: upstream is held while the buffered write goes out.
        WR1: begin
          RFWriteEn   <= write_allowed(pend_addr);
          RFWriteAddr <= pend_addr;
          RFWriteData <= pend_data;
          state       <= WR2;
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Scoreboard bench for wb_write_sequencer: expected writes are queued with
// the cycle they must appear in; a monitor pops and compares on each write strobe.
module tb_wb_write_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid, RegWrite, WriteOP2, Halt, Overflow;
  logic [3:0]  DestOP1, DestOP2;
  logic [15:0] ResultOP1, ResultOP2;
  logic        Stall, RFWriteEn, OverflowFlag, Halted;
  logic [3:0]  RFWriteAddr;
  logic [15:0] RFWriteData;
  logic [7:0]  OverflowCount;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
    int          cyc;
  } wr_t;

  wr_t q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_write_sequencer dut (
    .clk(clk), .rst(rst), .InValid(InValid), .RegWrite(RegWrite),
    .WriteOP2(WriteOP2), .Halt(Halt), .Overflow(Overflow),
    .DestOP1(DestOP1), .DestOP2(DestOP2), .ResultOP1(ResultOP1),
    .ResultOP2(ResultOP2), .Stall(Stall), .RFWriteEn(RFWriteEn),
    .RFWriteAddr(RFWriteAddr), .RFWriteData(RFWriteData),
    .OverflowFlag(OverflowFlag), .OverflowCount(OverflowCount), .Halted(Halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    InValid = 1'b0; RegWrite = 1'b0; WriteOP2 = 1'b0; Halt = 1'b0; Overflow = 1'b0;
    DestOP1 = 4'd0; DestOP2 = 4'd0; ResultOP1 = 16'd0; ResultOP2 = 16'd0;
  endtask

  task automatic drive(input logic rw, input logic op2, input logic h, input logic ov,
                       input logic [3:0] d1, input logic [15:0] r1,
                       input logic [3:0] d2, input logic [15:0] r2);
    InValid = 1'b1; RegWrite = rw; WriteOP2 = op2; Halt = h; Overflow = ov;
    DestOP1 = d1; ResultOP1 = r1; DestOP2 = d2; ResultOP2 = r2;
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [15:0] d, input int c);
    wr_t e;
    e.a = a; e.d = d; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"},    32'(RFWriteEn), 32'd0);
    chk({tag, "_addr"},  32'(RFWriteAddr), 32'd0);
    chk({tag, "_data"},  32'(RFWriteData), 32'd0);
    chk({tag, "_flag"},  32'(OverflowFlag), 32'd0);
    chk({tag, "_count"}, 32'(OverflowCount), 32'd0);
    chk({tag, "_halt"},  32'(Halted), 32'd0);
    chk({tag, "_stall"}, 32'(Stall), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    #2;
    check_zero("reset");
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0;
    idle_in();

    // Monitor: every write strobe must match the head of the scoreboard.
    fork
      forever begin : monitor
        wr_t e;
        @(negedge clk);
        if (RFWriteEn === 1'b1) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got r%0d=%0h expected no write (cyc=%0d)",
                     RFWriteAddr, RFWriteData, cyc);
          end else begin
            e = q.pop_front();
            chk("wr_addr",  32'(RFWriteAddr), 32'(e.a));
            chk("wr_data",  32'(RFWriteData), 32'(e.d));
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    join_none

    #1;
    do_reset();

    // 1: single write
    drive(1, 0, 0, 0, 4'd3, 16'h00A5, 4'd0, 16'h0000);
    expect_wr(4'd3, 16'h00A5, cyc + 1);
    step();
    idle_in();
    chk("t1_stall", 32'(Stall), 32'd0);
    step();

    // 2: swap, with the next instruction held valid through the stall
    drive(1, 1, 0, 0, 4'd2, 16'h1111, 4'd5, 16'h2222);
    expect_wr(4'd2, 16'h1111, cyc + 1);
    expect_wr(4'd5, 16'h2222, cyc + 2);
    expect_wr(4'd9, 16'h3333, cyc + 3);
    step();
    chk("t2_stall_wr1", 32'(Stall), 32'd1);
    drive(1, 0, 0, 0, 4'd9, 16'h3333, 4'd0, 16'h0000);
    step();
    chk("t2_stall_wr2", 32'(Stall), 32'd0);
    chk("t2_addr_wr2", 32'(RFWriteAddr), 32'd5);
    step();
    idle_in();
    chk("t2_addr_next", 32'(RFWriteAddr), 32'd9);
    step();

    // 3: overflow suppression and saturation
    drive(1, 0, 0, 1, 4'd4, 16'hDEAD, 4'd0, 16'h0000);
    step();
    chk("t3_flag_first", 32'(OverflowFlag), 32'd1);
    chk("t3_count_first", 32'(OverflowCount), 32'd1);
    for (int i = 1; i < 300; i++) step();
    idle_in();
    step();
    chk("t3_flag", 32'(OverflowFlag), 32'd1);
    chk("t3_count_sat", 32'(OverflowCount), 32'd255);

    // 4: halt has priority; HALTED absorbs inputs and freezes overflow state
    do_reset();
    drive(1, 0, 0, 1, 4'd1, 16'h0001, 4'd0, 16'h0000);
    step();
    drive(1, 0, 1, 0, 4'd6, 16'h6060, 4'd0, 16'h0000);
    step();
    chk("t4_halted", 32'(Halted), 32'd1);
    chk("t4_stall", 32'(Stall), 32'd1);
    drive(1, 0, 0, 1, 4'd8, 16'h8080, 4'd0, 16'h0000);
    step();
    drive(1, 1, 0, 0, 4'd8, 16'h8181, 4'd9, 16'h9191);
    step();
    step();
    idle_in();
    chk("t4_halted_hold", 32'(Halted), 32'd1);
    chk("t4_count_frozen", 32'(OverflowCount), 32'd1);
    chk("t4_flag_frozen", 32'(OverflowFlag), 32'd1);
    do_reset();

    // 5: r0 protection and swap onto the same register
    drive(1, 0, 0, 0, 4'd0, 16'hBEEF, 4'd0, 16'h0000);
    step();
    idle_in();
    chk("t5_r0_en", 32'(RFWriteEn), 32'd0);
    chk("t5_r0_data", 32'(RFWriteData), 32'hBEEF);
    step();
    drive(1, 1, 0, 0, 4'd7, 16'h0AAA, 4'd7, 16'h0BBB);
    expect_wr(4'd7, 16'h0AAA, cyc + 1);
    expect_wr(4'd7, 16'h0BBB, cyc + 2);
    step();
    idle_in();
    step();
    step();
    chk("t5_final_data", 32'(RFWriteData), 32'h0BBB);

    // 6: async reset during the first write of a swap drops the second
    drive(1, 1, 0, 0, 4'd4, 16'h4444, 4'd6, 16'h6666);
    expect_wr(4'd4, 16'h4444, cyc + 1);
    step();
    idle_in();
    chk("t6_stall_wr1", 32'(Stall), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("t6_async");
    step();
    step();
    rst = 1'b0;
    repeat (4) step();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_sequencer.md
Name: wb_write_sequencer

Overview:
- Write-back stage sequencer. It consumes the WB-stage control bits that the decode-side control unit produces (RegWrite, WriteOP2, Halt) together with the result and destination fields.
- It drives the single write port of the register file.
- A swap instruction (WriteOP2=1) needs two register writes. The block serialises them over two cycles and holds the upstream pipeline with Stall.
- It also owns the sticky overflow status and the halt latch.

Parameters:
- DATA_W, 16, width of result data and register-file write data.
- ADDR_W, 4, width of register addresses.
- PROTECT_R0, 1, when 1 a write addressed to register 0 is dropped (RFWriteEn stays 0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- InValid  in  1  WB-stage instruction valid this cycle.
- RegWrite  in  1  instruction writes the register file.
- WriteOP2  in  1  second write required (swap).
- Halt  in  1  instruction is HALT.
- Overflow  in  1  ALU overflow for this instruction.
- DestOP1  in  ADDR_W  first destination register.
- DestOP2  in  ADDR_W  second destination register.
- ResultOP1  in  DATA_W  data for DestOP1.
- ResultOP2  in  DATA_W  data for DestOP2.
- Stall  out  1  upstream must hold; input not accepted this cycle.
- RFWriteEn  out  1  register-file write strobe (registered).
- RFWriteAddr  out  ADDR_W  write address (registered).
- RFWriteData  out  DATA_W  write data (registered).
- OverflowFlag  out  1  sticky overflow status.
- OverflowCount  out  8  saturating count of suppressed writes.
- Halted  out  1  processor halted.

Behaviour:
- Reset (async, rst=1): state IDLE; RFWriteEn=0, RFWriteAddr=0, RFWriteData=0, OverflowFlag=0, OverflowCount=0, Halted=0, pending OP2 buffer cleared. Reset mid-swap discards the pending second write.
- Accept rule: inputs are sampled on a rising edge when InValid=1 and Stall=0. With Stall=1 or InValid=0, inputs are ignored.
- Stall is combinational from state: 1 in WR1 and HALTED, 0 in IDLE and WR2.
- State IDLE / WR2, on accept:
  - RegWrite=1, Overflow=0: next cycle RFWriteEn=1, RFWriteAddr=DestOP1, RFWriteData=ResultOP1.
  - If additionally WriteOP2=1: capture DestOP2 and ResultOP2 into the pending buffer and go to WR1. Otherwise go to IDLE.
  - RegWrite=1, Overflow=1: no write of either operand. OverflowFlag set to 1. OverflowCount increments, saturating at 255. Go to IDLE.
  - RegWrite=0: RFWriteEn=0 next cycle. WriteOP2 is ignored.
  - Halt=1: takes priority over RegWrite. No write, go to HALTED, Halted=1 on the next cycle.
  - No accept: RFWriteEn=0 next cycle; state IDLE.
- State WR1 (first write visible on the port, Stall=1): at the next edge, RFWriteEn=1, RFWriteAddr=pending DestOP2, RFWriteData=pending ResultOP2; go to WR2.
- WR2 behaves as IDLE; a new instruction is accepted at the edge ending WR2.
- Latency: one cycle from accept to the write on the port. A swap occupies two consecutive write cycles and costs one stall cycle.
- PROTECT_R0=1: any write whose address is 0 has RFWriteEn forced to 0. Address and data still update.
- DestOP1==DestOP2 on a swap: both writes occur in order, so ResultOP2 wins.
- HALTED: absorbing state, exited only by rst. Stall=1, RFWriteEn=0. OverflowFlag and OverflowCount are frozen.
- OverflowFlag is cleared only by rst.

Test Plan:
1. Reset, then accept RegWrite=1, DestOP1=3, ResultOP1=16'h00A5 -> next cycle RFWriteEn=1, RFWriteAddr=3, RFWriteData=00A5; Stall stays 0.
2. Swap: DestOP1=2/ResultOP1=1111, DestOP2=5/ResultOP2=2222, WriteOP2=1 -> cycle+1 write r2=1111 with Stall=1; cycle+2 write r5=2222 with Stall=0. A next instruction held valid during the stall is accepted only at the edge ending cycle+2.
3. RegWrite=1 with Overflow=1, repeated 300 times -> RFWriteEn never 1, OverflowFlag=1, OverflowCount=255.
4. Halt=1 together with RegWrite=1 -> no write, Halted=1 next cycle, Stall=1. Further valid inputs are ignored; rst returns all outputs to 0.
5. Write to r0 with PROTECT_R0=1 -> RFWriteEn=0. Swap with DestOP1=DestOP2=7 -> two writes, final data = ResultOP2.
6. Assert rst during WR1 of a swap -> the pending second write never appears; outputs are 0 immediately (async).
